mem_stage_sram: RTL and testbench

//  Parametrised pipeline MEM stage for the ARM core. Replaces the single-cycle data memory with a

---
 rtl/mem_stage_pkg.sv | 14 +
 rtl/sram_access_fsm.sv | 47 ++++
 rtl/mem_stage_sram.sv | 59 +++++
 tb/tb_mem_stage_sram.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared state encoding and sizing helpers for the SRAM-backed MEM stage.
package mem_stage_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    function automatic int byte_shift(input int n);
        return $clog2(n / 8);
    endfunction

    localparam int BYTE_SHIFT = byte_shift(32);

    function automatic int cnt_width(input int wait_cycles);
        return (wait_cycles > 1) ? $clog2(wait_cycles) : 1;
    endfunction
endpackage

// File: rtl/sram_access_fsm.sv
// sram_access_fsm: sequences one multi-cycle SRAM transfer, drives strobes and captures load data.
module sram_access_fsm
    import mem_stage_pkg::*;
#(
    parameter int N           = 32,
    parameter int WAIT_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req,
    input  logic         wr,
    input  logic [N-1:0] rdata,
    output logic         ready,
    output logic         we_n,
    output logic         oe_n,
    output logic [N-1:0] load_data
);
    localparam int CW = cnt_width(WAIT_CYCLES);

    state_t state, next;
    logic [CW-1:0] cnt;
    logic last;

    assign last = cnt == CW'(WAIT_CYCLES - 1);

    // Strobes decode the registered state, so an async reset drops them immediately.
    always_comb begin
        next  = state == IDLE   ? (req ? ACCESS : IDLE) :
                state == ACCESS ? (last ? DONE : ACCESS) : IDLE;
        ready = state == IDLE ? !req : state == DONE;
        we_n  = !(state == ACCESS && wr);
        oe_n  = !(state == ACCESS && !wr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            load_data <= '0;
        end else begin
            state <= next;
            cnt   <= state == ACCESS ? cnt + CW'(1) : '0;
            if (state == ACCESS && last && !wr)
                load_data <= rdata;
        end
    end
endmodule

// File: rtl/mem_stage_sram.sv
// mem_stage_sram: pipeline MEM stage backed by an external multi-cycle SRAM; stalls via ready.
module mem_stage_sram
    import mem_stage_pkg::*;
#(
    parameter int N           = 32,
    parameter int ADDR_W      = 16,
    parameter int WAIT_CYCLES = 4,
    parameter int BASE_ADDR   = 1024,
    parameter int DEST_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      ALU_ResIn,
    input  logic [N-1:0]      Value_RmIn,
    input  logic              MEM_R_ENIn,
    input  logic              MEM_W_ENIn,
    input  logic              WB_ENIn,
    input  logic [DEST_W-1:0] DestIn,
    input  logic [N-1:0]      sram_rdata,
    output logic [N-1:0]      ALU_ResOut,
    output logic [N-1:0]      DataMemoryOut,
    output logic              WB_ENOut,
    output logic              MEM_R_ENOut,
    output logic [DEST_W-1:0] DestOut,
    output logic              ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [N-1:0]      sram_wdata,
    output logic              sram_we_n,
    output logic              sram_oe_n
);
    localparam int SHIFT = byte_shift(N);
    localparam logic [N-1:0] BASE = N'(BASE_ADDR);

    logic [N-1:0] offset;

    // Byte offset bits are dropped; out-of-range addresses wrap in the SRAM word space.
    assign offset      = ALU_ResIn - BASE;
    assign sram_addr   = ADDR_W'(offset >> SHIFT);
    assign sram_wdata  = Value_RmIn;
    assign ALU_ResOut  = ALU_ResIn;
    assign MEM_R_ENOut = MEM_R_ENIn;
    assign DestOut     = DestIn;
    assign WB_ENOut    = WB_ENIn & ready;

    sram_access_fsm #(
        .N           (N),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_fsm (
        .clk       (clk),
        .rst       (rst),
        .req       (MEM_R_ENIn | MEM_W_ENIn),
        .wr        (MEM_W_ENIn),
        .rdata     (sram_rdata),
        .ready     (ready),
        .we_n      (sram_we_n),
        .oe_n      (sram_oe_n),
        .load_data (DataMemoryOut)
    );
endmodule

// File: tb/tb_mem_stage_sram.sv
// tb_mem_stage_sram: directed scoreboard bench for the SRAM-backed MEM stage.
module tb_mem_stage_sram;
    logic        clk = 0;
    logic        rst = 1;
    logic [31:0] alu_res = 0, value_rm = 0, rdata = 0;
    logic        mem_r = 0, mem_w = 0, wb_en = 0;
    logic [3:0]  dest = 0;
    logic [31:0] alu_out, dmo, wdata;
    logic        wb_out, mem_r_out, ready, we_n, oe_n;
    logic [3:0]  dest_out;
    logic [15:0] addr;

    typedef struct {
        int          stall;
        int          oe_cyc;
        int          we_cyc;
        int          wb_pulses;
        logic [31:0] dmo;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  dest;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_dmo = 0;

    mem_stage_sram dut (
        .clk           (clk),
        .rst           (rst),
        .ALU_ResIn     (alu_res),
        .Value_RmIn    (value_rm),
        .MEM_R_ENIn    (mem_r),
        .MEM_W_ENIn    (mem_w),
        .WB_ENIn       (wb_en),
        .DestIn        (dest),
        .sram_rdata    (rdata),
        .ALU_ResOut    (alu_out),
        .DataMemoryOut (dmo),
        .WB_ENOut      (wb_out),
        .MEM_R_ENOut   (mem_r_out),
        .DestOut       (dest_out),
        .ready         (ready),
        .sram_addr     (addr),
        .sram_wdata    (wdata),
        .sram_we_n     (we_n),
        .sram_oe_n     (oe_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one instruction, pushes its expectation, then watches the DUT until ready rises.
    task automatic run(input string tag, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] v, input logic [31:0] rd, input logic wb, input logic [3:0] d);
        exp_t e, got;
        int   n;
        logic done;
        mem_r = r; mem_w = w; alu_res = a; value_rm = v; rdata = rd; wb_en = wb; dest = d;
        if (r && !w) model_dmo = rd;
        e.stall     = (r || w) ? 5 : 0;
        e.oe_cyc    = (r && !w) ? 4 : 0;
        e.we_cyc    = w ? 4 : 0;
        e.wb_pulses = wb ? 1 : 0;
        e.dmo       = model_dmo;
        e.addr      = 16'((a - 32'd1024) >> 2);
        e.wdata     = v;
        e.dest      = d;
        sb.push_back(e);
        got = '{0, 0, 0, 0, 0, 0, 0, 0};
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (!oe_n) got.oe_cyc++;
            if (!we_n) got.we_cyc++;
            if (wb_out) got.wb_pulses++;
            if (ready) done = 1;
            else got.stall++;
        end
        e = sb.pop_front();
        chk({tag, ".ready_seen"}, 32'(done), 32'd1);
        chk({tag, ".stall"}, 32'(got.stall), 32'(e.stall));
        chk({tag, ".oe_cycles"}, 32'(got.oe_cyc), 32'(e.oe_cyc));
        chk({tag, ".we_cycles"}, 32'(got.we_cyc), 32'(e.we_cyc));
        chk({tag, ".wb_pulses"}, 32'(got.wb_pulses), 32'(e.wb_pulses));
        chk({tag, ".dmo"}, dmo, e.dmo);
        chk({tag, ".addr"}, 32'(addr), 32'(e.addr));
        chk({tag, ".wdata"}, wdata, e.wdata);
        chk({tag, ".dest"}, 32'(dest_out), 32'(e.dest));
        chk({tag, ".alu_out"}, alu_out, a);
        chk({tag, ".mem_r_out"}, 32'(mem_r_out), 32'(r));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3;
        chk("reset.dmo", dmo, 32'd0);
        chk("reset.we_n", 32'(we_n), 32'd1);
        chk("reset.oe_n", 32'(oe_n), 32'd1);
        chk("reset.ready", 32'(ready), 32'd1);
        @(posedge clk);
        #1 rst = 0;

        run("read", 1, 0, 32'd1032, 32'h0, 32'hDEADBEEF, 1, 4'd3);
        run("write", 0, 1, 32'd1028, 32'h12345678, 32'hAAAA5555, 0, 4'd0);
        run("alu", 0, 0, 32'h0000_0777, 32'h0, 32'h0, 1, 4'd5);
        run("b2b_load", 1, 0, 32'd1025 + 32'd8, 32'h0, 32'hCAFEF00D, 1, 4'd7);
        run("b2b_store", 0, 1, 32'd1036, 32'h0BADC0DE, 32'h11111111, 0, 4'd0);
        run("both", 1, 1, 32'd1040, 32'h55AA55AA, 32'h99999999, 0, 4'd2);
        run("wrap", 1, 0, 32'd1020, 32'h0, 32'h76543210, 1, 4'd9);
        run("alu_nowb", 0, 0, 32'h0000_0123, 32'h0, 32'h0, 0, 4'd1);

        // Abort a read mid-transfer with an asynchronous reset.
        mem_r = 1; mem_w = 0; alu_res = 32'd1044; rdata = 32'hFEEDFACE; wb_en = 1;
        @(negedge clk);
        @(negedge clk);
        chk("abort.oe_active", 32'(oe_n), 32'd0);
        #2 rst = 1;
        #1;
        chk("abort.oe_n", 32'(oe_n), 32'd1);
        chk("abort.we_n", 32'(we_n), 32'd1);
        chk("abort.dmo", dmo, 32'd0);
        mem_r = 0; wb_en = 0;
        #1;
        chk("abort.ready", 32'(ready), 32'd1);
        @(posedge clk);
        #1 rst = 0;
        model_dmo = 0;
        run("post_reset", 0, 0, 32'h10, 32'h0, 32'h0, 1, 4'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
